// File: rtl/proc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_controller: ProjectB sequencer (PC, IR, Moore control strobes).
// Optional single-step gating of FETCH under macro PROC_CTRL_STEP_EN. Rev 1.0
// ---------------------------------------------------------------------------
module proc_controller #(
  parameter int PC_W = 7,
  parameter int DA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef PROC_CTRL_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc_addr,
  input  logic [15:0]     instr,
  output logic [DA_W-1:0] d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic            rf_s,
  output logic [3:0]      rf_w_addr,
  output logic            rf_w_en,
  output logic [3:0]      rf_ra_addr,
  output logic [3:0]      rf_rb_addr,
  output logic [2:0]      alu_s,
  output logic            halted
);

  initial begin
    assert (DA_W == 8) else $fatal(1, "proc_controller: DA_W must be 8");
  end

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc;
  logic [15:0]      ir;
  logic             fetch_go;

`ifdef PROC_CTRL_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign pc_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && fetch_go) begin
        ir <= instr;
        pc <= pc + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_s      = 3'd0;
    halted     = 1'b0;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ir[15:12])
          4'h1:    state_nxt = S_STORE;
          4'h2:    state_nxt = S_LOAD_A;
          4'h3:    state_nxt = S_ADD;
          4'h4:    state_nxt = S_SUB;
          4'h5:    state_nxt = S_HALT;
          default: state_nxt = S_NOOP;
        endcase
      end
      S_NOOP:   state_nxt = S_FETCH;
      S_LOAD_A: begin
        d_addr    = DA_W'(ir[7:0]);
        d_rd      = 1'b1;
        state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        d_addr    = DA_W'(ir[7:0]);
        d_rd      = 1'b1;
        rf_s      = 1'b1;
        rf_w_addr = ir[11:8];
        rf_w_en   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_STORE: begin
        d_addr     = DA_W'(ir[11:4]);
        d_wr       = 1'b1;
        rf_ra_addr = ir[3:0];
        state_nxt  = S_FETCH;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir[11:8];
        rf_rb_addr = ir[7:4];
        alu_s      = (state == S_ADD) ? 3'd1 : 3'd2;
        rf_w_addr  = ir[3:0];
        rf_w_en    = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        // Only reset leaves HALT.
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default:  state_nxt = S_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_proc_controller: directed self-checking bench for proc_controller.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_proc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b1;
  logic [15:0] rom [0:127];

  // Main DUT (PC_W = 7)
  logic [6:0]  pc_addr;
  logic [15:0] instr;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr, rf_s, rf_w_en, halted;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s;

  // Narrow-PC DUT (PC_W = 2) running on an all-NOOP ROM
  logic [1:0]  pc_addr2;
  logic [7:0]  d_addr2;
  logic        d_rd2, d_wr2, rf_s2, rf_w_en2, halted2;
  logic [3:0]  rf_w_addr2, rf_ra_addr2, rf_rb_addr2;
  logic [2:0]  alu_s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign instr = rom[pc_addr];

  proc_controller #(.PC_W(7), .DA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PROC_CTRL_STEP_EN
    .step(step),
`endif
    .pc_addr(pc_addr), .instr(instr), .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
    .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_en(rf_w_en), .rf_ra_addr(rf_ra_addr),
    .rf_rb_addr(rf_rb_addr), .alu_s(alu_s), .halted(halted)
  );

  proc_controller #(.PC_W(2), .DA_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n),
`ifdef PROC_CTRL_STEP_EN
    .step(step),
`endif
    .pc_addr(pc_addr2), .instr(16'h0000), .d_addr(d_addr2), .d_rd(d_rd2), .d_wr(d_wr2),
    .rf_s(rf_s2), .rf_w_addr(rf_w_addr2), .rf_w_en(rf_w_en2), .rf_ra_addr(rf_ra_addr2),
    .rf_rb_addr(rf_rb_addr2), .alu_s(alu_s2), .halted(halted2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed non-PC outputs: {d_addr,d_rd,d_wr,rf_s,rf_w_addr,rf_w_en,ra,rb,alu_s,halted}
  function automatic logic [31:0] obs();
    return {4'h0, d_addr, d_rd, d_wr, rf_s, rf_w_addr, rf_w_en,
            rf_ra_addr, rf_rb_addr, alu_s, halted};
  endfunction

  function automatic logic [31:0] obs2();
    return {4'h0, d_addr2, d_rd2, d_wr2, rf_s2, rf_w_addr2, rf_w_en2,
            rf_ra_addr2, rf_rb_addr2, alu_s2, halted2};
  endfunction

  function automatic logic [31:0] ev(input logic [7:0] da, input logic rd, input logic wr,
                                     input logic s, input logic [3:0] wa, input logic wen,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [2:0] alu, input logic h);
    return {4'h0, da, rd, wr, s, wa, wen, ra, rb, alu, h};
  endfunction

  task automatic load_rom(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    for (int k = 0; k < 128; k++) rom[k] = 16'h0000;
    rom[0] = i0;
    rom[1] = i1;
    rom[2] = i2;
  endtask

  // Reset for two edges, release on a falling edge; returns in INIT.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    load_rom(16'h3125, 16'h0000, 16'h0000);

    // ---------------- Reset and ADD ----------------
    do_reset();
    check("init_pc", 32'(pc_addr), 32'd0);
    check("init_outs", obs(), 32'd0);
    cyc(1);
    check("fetch0_pc", 32'(pc_addr), 32'd0);
    check("fetch0_outs", obs(), 32'd0);
    cyc(1);
    check("decode_pc", 32'(pc_addr), 32'd1);
    check("decode_outs", obs(), 32'd0);
    cyc(1);
    check("add_outs", obs(), ev(8'h00, 0, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1, 0));
    cyc(1);
    check("add_next_fetch_pc", 32'(pc_addr), 32'd1);
    check("add_next_fetch_outs", obs(), 32'd0);

    // ---------------- LOAD then STORE ----------------
    load_rom(16'h2A1B, 16'h11BA, 16'h0000);
    do_reset();
    cyc(3);
    check("load_a_outs", obs(), ev(8'h1B, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0));
    cyc(1);
    check("load_b_outs", obs(), ev(8'h1B, 1, 0, 1, 4'hA, 1, 4'h0, 4'h0, 3'd0, 0));
    cyc(1);
    check("load_next_fetch_pc", 32'(pc_addr), 32'd1);
    check("load_next_fetch_outs", obs(), 32'd0);
    cyc(2);
    check("store_outs", obs(), ev(8'h1B, 0, 1, 0, 4'h0, 0, 4'hA, 4'h0, 3'd0, 0));
    cyc(1);
    check("store_next_fetch_outs", obs(), 32'd0);

    // ---------------- SUB, invalid opcode, HALT ----------------
    load_rom(16'h4348, 16'hF000, 16'h5000);
    do_reset();
    cyc(3);
    check("sub_outs", obs(), ev(8'h00, 0, 0, 0, 4'h8, 1, 4'h3, 4'h4, 3'd2, 0));
    cyc(3);
    check("invalid_op_outs", obs(), 32'd0);
    check("invalid_op_pc", 32'(pc_addr), 32'd2);
    cyc(2);
    check("halt_decode_outs", obs(), 32'd0);
    cyc(1);
    check("halt_outs", obs(), ev(8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1));
    check("halt_pc", 32'(pc_addr), 32'd3);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("halt_hold_outs", obs(), ev(8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1));
      check("halt_hold_pc", 32'(pc_addr), 32'd3);
    end

    // ---------------- PC wrap on PC_W=2 DUT ----------------
    load_rom(16'h0000, 16'h0000, 16'h0000);
    do_reset();
    begin
      logic [1:0] exp_pc [0:4];
      int strobe_hits;
      exp_pc[0] = 2'd0; exp_pc[1] = 2'd1; exp_pc[2] = 2'd2; exp_pc[3] = 2'd3; exp_pc[4] = 2'd0;
      strobe_hits = 0;
      for (int k = 0; k < 5; k++) begin
        cyc(1);
        check("wrap_fetch_pc", 32'(pc_addr2), 32'(exp_pc[k]));
        if (obs2() != 32'd0) strobe_hits++;
        cyc(1);
        if (obs2() != 32'd0) strobe_hits++;
        cyc(1);
        if (obs2() != 32'd0) strobe_hits++;
      end
      check("wrap_no_strobes", 32'(strobe_hits), 32'd0);
    end

    // ---------------- Asynchronous reset during LOAD_A ----------------
    load_rom(16'h2A1B, 16'h0000, 16'h0000);
    do_reset();
    cyc(3);
    check("midrst_load_a", 32'(d_rd), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs_async", obs(), 32'd0);
    check("midrst_pc_async", 32'(pc_addr), 32'd0);
    cyc(1);
    check("midrst_wen_after_edge", 32'(rf_w_en), 32'd0);
    check("midrst_outs_after_edge", obs(), 32'd0);
    rst_n = 1'b1;
    check("midrst_init_outs", obs(), 32'd0);

`ifdef PROC_CTRL_STEP_EN
    // ---------------- Single-step gating ----------------
    load_rom(16'h3125, 16'h0000, 16'h0000);
    step = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("step_hold_pc", 32'(pc_addr), 32'd0);
      check("step_hold_outs", obs(), 32'd0);
    end
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check("step_decode_pc", 32'(pc_addr), 32'd1);
    cyc(1);
    check("step_add_outs", obs(), ev(8'h00, 0, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1, 0));
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("step_wait_pc", 32'(pc_addr), 32'd1);
      check("step_wait_outs", obs(), 32'd0);
    end
    step = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
